iobuf_bank_reg: RTL and testbench



---
 rtl/iobuf_pkg.sv | 18 +
 rtl/iobuf_sync_chain.sv | 30 +++
 rtl/iobuf_bank_reg.sv | 117 +++++++++++
 tb/tb_iobuf_bank_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/iobuf_pkg.sv
// rtl/iobuf_pkg.sv - shared types and bounds for the registered I/O bank
package iobuf_pkg;

    // Tristate control states: released, waiting out the turnaround, actively driving
    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } iob_state_t;

    localparam int TURN_CNT_W = 4;

    localparam int TURN_CYCLES_MIN = 0;
    localparam int TURN_CYCLES_MAX = 15;
    localparam int SYNC_STAGES_MIN = 1;
    localparam int SYNC_STAGES_MAX = 3;

endpackage

// File: rtl/iobuf_sync_chain.sv
// rtl/iobuf_sync_chain.sv - multi-stage input capture shift chain
module iobuf_sync_chain #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Shift pad samples through the chain every edge; Z/X are carried unmodified
    always_ff @(posedge C) begin
        if (R) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= D;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign Q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/iobuf_bank_reg.sv
// rtl/iobuf_bank_reg.sv - registered bidirectional I/O bank with drive turnaround
module iobuf_bank_reg
    import iobuf_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2,
    parameter bit OPEN_DRAIN  = 1'b0,
    parameter bit INIT_O      = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    input  logic             T,
    inout  wire  [WIDTH-1:0] IO,
    output logic [WIDTH-1:0] O,
    output logic             DRIVING
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "iobuf_bank_reg: WIDTH must be >= 1");
    end
    if (TURN_CYCLES < TURN_CYCLES_MIN || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_turn
        $fatal(1, "iobuf_bank_reg: TURN_CYCLES out of range 0..15");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $fatal(1, "iobuf_bank_reg: SYNC_STAGES out of range 1..3");
    end

    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN_CYCLES - 1);

    logic [WIDTH-1:0]      oq;
    iob_state_t            state;
    iob_state_t            state_nxt;
    logic [TURN_CNT_W-1:0] cnt;
    logic [TURN_CNT_W-1:0] cnt_nxt;

    // Output data register; reset value comes from INIT_O, CE gates loading
    always_ff @(posedge C) begin
        if (R) begin
            oq <= {WIDTH{INIT_O}};
        end else if (CE) begin
            oq <= I;
        end
    end

    // Tristate FSM state and turnaround counter; CE=0 freezes both mid-turnaround
    always_ff @(posedge C) begin
        if (R) begin
            state <= HIZ;
            cnt   <= '0;
        end else if (CE) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: a release request always wins over turnaround expiry
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            HIZ: begin
                if (!T) begin
                    if (TURN_CYCLES == 0) begin
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = TURN;
                        cnt_nxt   = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                if (T) begin
                    state_nxt = HIZ;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = DRIVE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DRIVE: begin
                if (T) begin
                    state_nxt = HIZ;
                end
            end
            default: begin
                state_nxt = HIZ;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decoded from the state register only, so T has no combinational path to the pad
    assign DRIVING = (state == DRIVE);

    if (OPEN_DRAIN) begin : g_od
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            assign IO[b] = (DRIVING && !oq[b]) ? 1'b0 : 1'bz;
        end
    end else begin : g_pp
        assign IO = DRIVING ? oq : {WIDTH{1'bz}};
    end

    iobuf_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .C (C),
        .R (R),
        .D (IO),
        .Q (O)
    );

endmodule

// File: tb/tb_iobuf_bank_reg.sv
// tb/tb_iobuf_bank_reg.sv - scoreboard bench for the registered I/O bank
module tb_iobuf_bank_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r_a, ce_a, t_a, drv_a;
    logic [7:0] i_a, o_a, ext_a, ext_en_a;
    wire  [7:0] io_a;

    logic       r_b, ce_b, t_b, drv_b;
    logic [7:0] i_b, o_b, ext_b, ext_en_b;
    wire  [7:0] io_b;

    for (genvar g = 0; g < 8; g++) begin : g_ext
        assign io_a[g] = ext_en_a[g] ? ext_a[g] : 1'bz;
        assign io_b[g] = ext_en_b[g] ? ext_b[g] : 1'bz;
    end

    iobuf_bank_reg #(
        .WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2), .OPEN_DRAIN(1'b0), .INIT_O(1'b1)
    ) dut_a (
        .C(clk), .R(r_a), .CE(ce_a), .I(i_a), .T(t_a), .IO(io_a), .O(o_a), .DRIVING(drv_a)
    );

    iobuf_bank_reg #(
        .WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(3), .OPEN_DRAIN(1'b1), .INIT_O(1'b0)
    ) dut_b (
        .C(clk), .R(r_b), .CE(ce_b), .I(i_b), .T(t_b), .IO(io_b), .O(o_b), .DRIVING(drv_b)
    );

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] probe(int sel);
        case (sel)
            0: return o_a;
            1: return io_a;
            2: return {7'b0, drv_a};
            3: return o_b;
            4: return io_b;
            5: return {7'b0, drv_b};
            6: return dut_a.oq;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic sb_push(input int sel, input logic [7:0] v, input int d, input string nm);
        exp_t e;
        e.due  = cyc + d;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due == cyc) begin
                logic [7:0] act;
                act = probe(sb[j].sel);
                checks++;
                if (act !== sb[j].exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%h expected=%h", sb[j].name, cyc, act, sb[j].exp);
                end
                sb.delete(j);
            end else if (sb[j].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed cyc=%0d due=%0d", sb[j].name, cyc, sb[j].due);
                sb.delete(j);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        r_a = 1; ce_a = 1; t_a = 1; i_a = 8'h12; ext_a = 8'h00; ext_en_a = 8'hFF;
        r_b = 1; ce_b = 1; t_b = 1; i_b = 8'h00; ext_b = 8'h00; ext_en_b = 8'hFF;
        tick(); tick();
        sb_push(2, 8'h00, 0, "rst_drv_a");
        sb_push(0, 8'h00, 0, "rst_o_a");
        sb_push(1, 8'h00, 0, "rst_io_a");
        sb_push(6, 8'hFF, 0, "rst_oq_a");
        sb_push(5, 8'h00, 0, "rst_drv_b");
        sb_push(3, 8'h00, 0, "rst_o_b");

        // Leave reset with CE low: oq keeps its INIT_O value
        r_a = 0; r_b = 0; ce_a = 0; i_a = 8'h77;
        tick();
        sb_push(6, 8'hFF, 0, "oq_hold_init");

        // Turnaround: drive appears on the third enabled edge after the request
        ce_a = 1; i_a = 8'hA5; t_a = 0;
        sb_push(2, 8'h00, 1, "turn_drv_k");
        sb_push(1, 8'h00, 1, "turn_io_k");
        sb_push(2, 8'h00, 2, "turn_drv_k1");
        sb_push(1, 8'h00, 2, "turn_io_k1");
        sb_push(2, 8'h01, 3, "turn_drv_k2");
        sb_push(1, 8'hA5, 3, "turn_io_k2");
        sb_push(0, 8'hA5, 5, "loop_o_a");
        tick(); tick(); ext_en_a = 8'h00; tick(); tick(); tick();

        // Release from DRIVE takes one edge; loopback drains after two more
        t_a = 1;
        sb_push(2, 8'h00, 1, "rel_drv");
        sb_push(1, 8'h00, 1, "rel_io");
        sb_push(0, 8'hA5, 2, "rel_o_hold");
        sb_push(0, 8'h00, 3, "rel_o_clr");
        tick(); ext_en_a = 8'hFF; tick(); tick();

        // Abort during TURN, then restart the full delay
        t_a = 0;
        sb_push(2, 8'h00, 1, "abort_turn");
        sb_push(2, 8'h00, 2, "abort_hiz");
        sb_push(2, 8'h00, 3, "restart_t1");
        sb_push(2, 8'h00, 4, "restart_t2");
        sb_push(2, 8'h01, 5, "restart_drv");
        sb_push(1, 8'hA5, 5, "restart_io");
        tick(); t_a = 1; tick(); t_a = 0; tick(); tick(); ext_en_a = 8'h00; tick();
        t_a = 1;
        tick(); ext_en_a = 8'hFF;
        sb_push(2, 8'h00, 0, "rel2_drv");
        tick(); tick();

        // CE freeze for 4 edges mid-turnaround
        i_a = 8'h3C; t_a = 0; ce_a = 1;
        sb_push(2, 8'h00, 1, "frz_drv_f");
        sb_push(2, 8'h00, 5, "frz_drv_held");
        sb_push(6, 8'h3C, 5, "frz_oq_hold");
        sb_push(2, 8'h00, 6, "frz_drv_f5");
        sb_push(2, 8'h01, 7, "frz_drv_on");
        sb_push(1, 8'h5A, 7, "frz_io");
        tick();
        ce_a = 0; i_a = 8'h99;
        tick(); tick(); tick(); tick();
        ce_a = 1; i_a = 8'h5A;
        tick(); ext_en_a = 8'h00; tick();

        // Reset while driving releases the pad at the reset edge
        r_a = 1;
        sb_push(2, 8'h00, 1, "rstdrv_drv");
        sb_push(6, 8'hFF, 1, "rstdrv_oq");
        tick(); ext_en_a = 8'hFF;
        sb_push(1, 8'h00, 0, "rstdrv_io");
        r_a = 0; t_a = 1;
        tick();

        // Open-drain: oq=F0 pulls IO[3:0] low, IO[7:4] released to the pull-ups
        i_b = 8'hF0; t_b = 0; ext_b = 8'hF0; ext_en_b = 8'hF0;
        sb_push(5, 8'h00, 2, "od_drv_k1");
        sb_push(5, 8'h01, 3, "od_drv_on");
        sb_push(4, 8'hF0, 3, "od_io");
        sb_push(3, 8'hF0, 6, "od_o");
        tick(); tick(); tick(); tick(); tick(); tick();

        // Receive path with a 3-stage chain
        t_b = 1; ext_b = 8'h00; ext_en_b = 8'hFF;
        sb_push(5, 8'h00, 1, "rx_drv_off");
        tick(); tick(); tick(); tick();
        ext_b = 8'h3C;
        sb_push(3, 8'h00, 2, "rx_o_pre");
        sb_push(3, 8'h3C, 3, "rx_o_3c");
        sb_push(3, 8'h3C, 4, "rx_o_3c_hold");
        sb_push(3, 8'hC3, 5, "rx_o_c3");
        tick(); tick(); ext_b = 8'hC3; tick(); tick(); tick();

        // Reset mid-stream clears the chain at the reset edge
        ext_b = 8'h55; r_b = 1;
        sb_push(3, 8'h00, 1, "rx_rst_o");
        sb_push(3, 8'h00, 2, "rx_rst_o2");
        sb_push(3, 8'h55, 4, "rx_post_rst");
        tick(); r_b = 0; tick(); tick(); tick();

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
